// File: rtl/testdrive_axi4_pkg.sv
// Shared AXI4 encodings, read-DMA FSM states and the 4KB page constant
// used by the read DMA and its burst-length calculator.
package testdrive_axi4_pkg;

   localparam logic [1:0] AXI_BURST_INCR   = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR  = 2'b10;
   localparam logic [3:0] AXI_CACHE_BUF_MOD = 4'b0011;
   localparam int         BOUNDARY_4K      = 4096;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } rdma_state_t;

endpackage

// File: rtl/testdrive_axi4_burst_len.sv
// Combinational burst length: min(remaining beats, C_MAX_BURST, beats left
// before the next 4KB page boundary). Result is 1..256 for remaining > 0.
module testdrive_axi4_burst_len
   import testdrive_axi4_pkg::*;
#(
   parameter int C_DATA_WIDTH = 128,
   parameter int C_MAX_BURST  = 16
) (
   input  logic [11:0] addr,
   input  logic [15:0] remaining,
   output logic [8:0]  len
);
   localparam int LG         = $clog2(C_DATA_WIDTH / 8);
   localparam int PAGE_BEATS = BOUNDARY_4K >> LG;

   logic [12:0] to_4k;
   logic [15:0] lim;
   logic        unused_low;

   // Only the beat index within the page matters; the byte offset is aligned.
   assign to_4k      = 13'(PAGE_BEATS) - 13'(addr[11:LG]);
   assign unused_low = ^addr[LG-1:0];

   always_comb begin
      lim = remaining;
      if (lim > 16'(C_MAX_BURST)) lim = 16'(C_MAX_BURST);
      if (lim > 16'(to_4k))       lim = 16'(to_4k);
      len = 9'(lim);
   end

endmodule

// File: rtl/testdrive_axi4_read_dma.sv
// AXI4 read DMA: splits a command into 4KB-safe INCR bursts, one outstanding,
// and streams R data straight to OUT. Define TESTDRIVE_AXI4_RDMA_RCHECK_EN to flag RID/RLAST errors.
module testdrive_axi4_read_dma
   import testdrive_axi4_pkg::*;
#(
   parameter int C_THREAD_ID_WIDTH = 1,
   parameter int C_ADDR_WIDTH      = 32,
   parameter int C_DATA_WIDTH      = 128,
   parameter int C_MAX_BURST       = 16,
   parameter int C_ARID            = 0
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         CMD_VALID,
   output logic                         CMD_READY,
   input  logic [C_ADDR_WIDTH-1:0]      CMD_ADDR,
   input  logic [15:0]                  CMD_BEATS,
   output logic [C_THREAD_ID_WIDTH-1:0] ARID,
   output logic [C_ADDR_WIDTH-1:0]      ARADDR,
   output logic [7:0]                   ARLEN,
   output logic [2:0]                   ARSIZE,
   output logic [1:0]                   ARBURST,
   output logic                         ARLOCK,
   output logic [3:0]                   ARCACHE,
   output logic [2:0]                   ARPROT,
   output logic                         ARVALID,
   input  logic                         ARREADY,
   input  logic [C_THREAD_ID_WIDTH-1:0] RID,
   input  logic [C_DATA_WIDTH-1:0]      RDATA,
   input  logic [1:0]                   RRESP,
   input  logic                         RLAST,
   input  logic                         RVALID,
   output logic                         RREADY,
   output logic [C_DATA_WIDTH-1:0]      OUT_DATA,
   output logic                         OUT_VALID,
   output logic                         OUT_LAST,
   input  logic                         OUT_READY,
   output logic                         BUSY,
   output logic                         DONE,
   output logic                         ERR,
   output logic [1:0]                   dbg_state
);
   localparam int LG = $clog2(C_DATA_WIDTH / 8);
   localparam logic [C_THREAD_ID_WIDTH-1:0] ARID_VAL = C_THREAD_ID_WIDTH'(C_ARID);

   // Handshakes: a transfer happens on a rising CLK where valid and ready are both high;
   // valid never waits on ready, and AR fields hold steady while ARVALID is unanswered.
   rdma_state_t             state;
   logic [15:0]             rem;
   logic [8:0]              burst_left;
   logic [C_ADDR_WIDTH-1:0] next_addr;
   logic [C_ADDR_WIDTH-1:0] calc_addr;
   logic [15:0]             calc_rem;
   logic [8:0]              calc_len;
   logic                    in_data, beat_fire, last_of_burst, beat_err;

   assign next_addr = ARADDR + (C_ADDR_WIDTH'({1'b0, ARLEN} + 9'd1) << LG);
   // In IDLE the calculator sizes the first burst of the incoming command.
   assign calc_addr = (state == ST_IDLE) ? CMD_ADDR  : next_addr;
   assign calc_rem  = (state == ST_IDLE) ? CMD_BEATS : rem;

   testdrive_axi4_burst_len #(
      .C_DATA_WIDTH (C_DATA_WIDTH),
      .C_MAX_BURST  (C_MAX_BURST)
   ) u_burst_len (
      .addr      (calc_addr[11:0]),
      .remaining (calc_rem),
      .len       (calc_len)
   );

   assign in_data       = (state == ST_DATA);
   assign last_of_burst = (burst_left == 9'd1);
   assign beat_fire     = in_data && RVALID && OUT_READY;

   assign RREADY    = in_data && OUT_READY;
   assign OUT_VALID = in_data && RVALID;
   assign OUT_DATA  = RDATA;
   assign OUT_LAST  = in_data && RVALID && last_of_burst && (rem == 16'd0);

   assign ARID      = ARID_VAL;
   assign ARSIZE    = 3'(LG);
   assign ARBURST   = AXI_BURST_INCR;
   assign ARLOCK    = 1'b0;
   assign ARCACHE   = AXI_CACHE_BUF_MOD;
   assign ARPROT    = 3'b000;
   assign dbg_state = state;

`ifdef TESTDRIVE_AXI4_RDMA_RCHECK_EN
   assign beat_err = (RRESP != AXI_RESP_OKAY) || (RID != ARID_VAL) || (RLAST != last_of_burst);
`else
   logic unused_rchk;
   assign beat_err    = (RRESP != AXI_RESP_OKAY);
   assign unused_rchk = ^{RID, RLAST};
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= ST_IDLE;
         ARVALID    <= 1'b0;
         ARADDR     <= '0;
         ARLEN      <= '0;
         rem        <= '0;
         burst_left <= '0;
         CMD_READY  <= 1'b1;
         BUSY       <= 1'b0;
         DONE       <= 1'b0;
         ERR        <= 1'b0;
      end else begin
         DONE <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (CMD_VALID) begin
                  if (CMD_BEATS == 16'd0) begin
                     DONE <= 1'b1;
                  end else begin
                     ARADDR     <= CMD_ADDR;
                     ARLEN      <= 8'(calc_len - 9'd1);
                     rem        <= CMD_BEATS - 16'(calc_len);
                     burst_left <= calc_len;
                     ARVALID    <= 1'b1;
                     ERR        <= 1'b0;
                     BUSY       <= 1'b1;
                     CMD_READY  <= 1'b0;
                     state      <= ST_ADDR;
                  end
               end
            end
            ST_ADDR: begin
               if (ARREADY) begin
                  ARVALID <= 1'b0;
                  state   <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (beat_fire) begin
                  if (beat_err) ERR <= 1'b1;
                  burst_left <= burst_left - 9'd1;
                  if (last_of_burst) begin
                     if (rem == 16'd0) begin
                        DONE      <= 1'b1;
                        BUSY      <= 1'b0;
                        CMD_READY <= 1'b1;
                        state     <= ST_IDLE;
                     end else begin
                        ARADDR     <= next_addr;
                        ARLEN      <= 8'(calc_len - 9'd1);
                        rem        <= rem - 16'(calc_len);
                        burst_left <= calc_len;
                        ARVALID    <= 1'b1;
                        state      <= ST_ADDR;
                     end
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_testdrive_axi4_read_dma.sv
// Directed bench for testdrive_axi4_read_dma: an AXI read slave, a burst/beat
// model of each command, and a per-cycle compare process.
module tb_testdrive_axi4_read_dma;
   localparam int AW = 32;
   localparam int DW = 128;

   logic          clk = 1'b0;
   logic          rst;
   logic          CMD_VALID, CMD_READY;
   logic [AW-1:0] CMD_ADDR;
   logic [15:0]   CMD_BEATS;
   logic [0:0]    ARID, RID;
   logic [AW-1:0] ARADDR;
   logic [7:0]    ARLEN;
   logic [2:0]    ARSIZE, ARPROT;
   logic [1:0]    ARBURST, RRESP;
   logic          ARLOCK, ARVALID, ARREADY;
   logic [3:0]    ARCACHE;
   logic [DW-1:0] RDATA, OUT_DATA;
   logic          RLAST, RVALID, RREADY;
   logic          OUT_VALID, OUT_LAST, OUT_READY;
   logic          BUSY, DONE, ERR;
   logic [1:0]    dbg_state;

   always #5 clk = ~clk;

   testdrive_axi4_read_dma dut (
      .CLK(clk), .RST(rst), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
      .CMD_ADDR(CMD_ADDR), .CMD_BEATS(CMD_BEATS), .ARID(ARID), .ARADDR(ARADDR),
      .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARLOCK(ARLOCK),
      .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
      .RREADY(RREADY), .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_LAST(OUT_LAST),
      .OUT_READY(OUT_READY), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .dbg_state(dbg_state)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [DW-1:0] mem_word(input logic [31:0] a);
      return {a ^ 32'h1111_0000, ~a, a + 32'd7, a};
   endfunction

   // Scoreboard: expected AR bursts {addr,len} and expected beats {last,data}.
   logic [39:0]  exp_ar_q[$];
   logic [128:0] exp_q[$];
   logic         exp_err = 1'b0;
   logic [31:0]  ar_log_addr[8];
   logic [7:0]   ar_log_len[8];
   int           ar_n = 0, out_cnt = 0, last_cnt = 0, done_cnt = 0, done_start = 0;
   int           err_beat = -1, cmd_beat = 0;

   // Reference model: burst splitting from the length rule, then the beat sequence.
   task automatic model_cmd(input logic [31:0] addr, input int beats);
      longint a = addr;
      int rem = beats;
      int len, to4k;
      while (rem > 0) begin
         len  = (rem > 16) ? 16 : rem;
         to4k = (4096 - int'(a % 4096)) / 16;
         if (len > to4k) len = to4k;
         exp_ar_q.push_back({a[31:0], 8'(len - 1)});
         a   += len * 16;
         rem -= len;
      end
      for (int k = 0; k < beats; k++)
         exp_q.push_back({(k == beats - 1), mem_word(addr + 32'(16 * k))});
   endtask

   // AXI read slave: ARREADY after two wait cycles, RVALID held whenever a burst is open.
   logic [31:0] s_addr;
   int s_len, s_beat, ar_wait;
   logic s_active;
   initial begin
      logic ar_fire, r_fire, av;
      logic [31:0] a_addr;
      logic [7:0] a_len;
      ARREADY = 0; RVALID = 0; RDATA = '0; RRESP = 0; RLAST = 0; RID = 0;
      s_active = 0; s_beat = 0; s_len = 0; s_addr = 0; ar_wait = 0;
      forever begin
         @(negedge clk);
         ar_fire = ARVALID && ARREADY;
         r_fire  = RVALID && RREADY;
         av = ARVALID; a_addr = ARADDR; a_len = ARLEN;
         @(posedge clk); #1;
         if (rst) begin
            s_active = 0; RVALID = 0; ARREADY = 0; ar_wait = 0;
            continue;
         end
         if (ar_fire) begin
            s_addr = a_addr; s_len = int'(a_len); s_beat = 0; s_active = 1;
            ARREADY = 0; ar_wait = 0;
         end else if (av && !ARREADY) begin
            ar_wait++;
            if (ar_wait >= 2) ARREADY = 1;
         end
         if (r_fire) begin
            s_beat++; cmd_beat++;
            if (s_beat > s_len) s_active = 0;
         end
         RVALID = s_active;
         RDATA  = s_active ? mem_word(s_addr + 32'(16 * s_beat)) : '0;
         RLAST  = s_active && (s_beat == s_len);
         RRESP  = (s_active && cmd_beat == err_beat) ? 2'b10 : 2'b00;
      end
   end

   // Compare process: every negedge outside reset.
   initial begin
      logic hold_v = 0, prev_done = 0;
      logic [31:0] hold_addr;
      logic [7:0] hold_len;
      logic [39:0] ar_e;
      logic [128:0] o_e;
      forever begin
         @(negedge clk);
         if (rst) begin hold_v = 0; prev_done = 0; continue; end
         if (hold_v) begin
            check("ar_hold_valid", ARVALID, 1);
            check("ar_hold_addr", ARADDR, hold_addr);
            check("ar_hold_len", ARLEN, hold_len);
         end
         hold_v = ARVALID && !ARREADY; hold_addr = ARADDR; hold_len = ARLEN;
         if (ARVALID) begin
            check("ar_one_outstanding", s_active, 0);
            check("ar_busy", BUSY, 1);
         end
         if (ARVALID && ARREADY) begin
            if (exp_ar_q.size() == 0) check("ar_unexpected", 1, 0);
            else begin
               ar_e = exp_ar_q.pop_front();
               check("ar_addr", ARADDR, ar_e[39:8]);
               check("ar_len", ARLEN, ar_e[7:0]);
            end
            check("ar_fixed", {ARID, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT},
                  {1'b0, 3'd4, 2'b01, 1'b0, 4'b0011, 3'b000});
            if (ar_n < 8) begin ar_log_addr[ar_n] = ARADDR; ar_log_len[ar_n] = ARLEN; end
            ar_n++;
         end
         if (!OUT_VALID) check("out_last_idle", OUT_LAST, 0);
         if (OUT_VALID) begin
            check("rready_eq_out_ready", RREADY, OUT_READY);
            check("out_data_pass", OUT_DATA, RDATA);
         end
         if (OUT_VALID && OUT_READY) begin
            if (exp_q.size() == 0) check("beat_unexpected", 1, 0);
            else begin
               o_e = exp_q.pop_front();
               check("beat_data", OUT_DATA, o_e[127:0]);
               check("beat_last", OUT_LAST, o_e[128]);
            end
            out_cnt++;
            if (OUT_LAST) last_cnt++;
         end
         check("cmd_ready_not_busy", CMD_READY, !BUSY);
         if (DONE) begin
            check("done_pulse", prev_done, 0);
            check("done_err", ERR, exp_err);
            check("done_ar_drained", exp_ar_q.size(), 0);
            check("done_beats_drained", exp_q.size(), 0);
            done_cnt++;
         end
         prev_done = DONE;
      end
   end

   task automatic issue_cmd(input logic [31:0] addr, input int beats, input int eb);
      int n = 0;
      while (!CMD_READY && n < 300) begin @(posedge clk); #1; n++; end
      if (!CMD_READY) check("cmd_ready_timeout", 0, 1);
      err_beat = eb; cmd_beat = 0; ar_n = 0; out_cnt = 0; last_cnt = 0;
      done_start = done_cnt;
      if (beats > 0) exp_err = (eb >= 0 && eb < beats);
      model_cmd(addr, beats);
      CMD_VALID = 1; CMD_ADDR = addr; CMD_BEATS = 16'(beats);
      @(posedge clk); #1;
      CMD_VALID = 0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (done_cnt == done_start && n < 500) begin @(posedge clk); #1; n++; end
      if (done_cnt == done_start) check({name, "_done_timeout"}, 0, 1);
   endtask

   task automatic stall_out(input int after_beats);
      int n = 0;
      while (out_cnt < after_beats && n < 300) begin @(posedge clk); #1; n++; end
      OUT_READY = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_rready_low", RREADY, 0);
      end
      @(posedge clk); #1;
      OUT_READY = 1;
   endtask

   initial begin
      int n;
      rst = 1; CMD_VALID = 0; CMD_ADDR = 0; CMD_BEATS = 0; OUT_READY = 1;
      #2;
      check("rst_outputs", {ARVALID, RREADY, OUT_VALID, OUT_LAST, BUSY, DONE, ERR}, 0);
      check("rst_ar_fields", {ARADDR, ARLEN}, 0);
      check("rst_cmd_ready", CMD_READY, 1);
      repeat (3) @(posedge clk);
      #1 rst = 0;

      // Single burst.
      issue_cmd(32'h1000, 4, -1);
      check("t1_busy", BUSY, 1);
      wait_done("t1");
      check("t1_ar_count", ar_n, 1);
      check("t1_ar0", {ar_log_addr[0], ar_log_len[0]}, {32'h1000, 8'd3});
      check("t1_beats", out_cnt, 4);
      check("t1_last_count", last_cnt, 1);

      // 4KB boundary split.
      issue_cmd(32'h0FC0, 8, -1);
      wait_done("t2");
      check("t2_ar_count", ar_n, 2);
      check("t2_ar0", {ar_log_addr[0], ar_log_len[0]}, {32'h0FC0, 8'd3});
      check("t2_ar1", {ar_log_addr[1], ar_log_len[1]}, {32'h1000, 8'd3});
      check("t2_last_count", last_cnt, 1);

      // Max-burst split.
      issue_cmd(32'h0000, 40, -1);
      wait_done("t3");
      check("t3_ar_count", ar_n, 3);
      check("t3_ar0", {ar_log_addr[0], ar_log_len[0]}, {32'h000, 8'd15});
      check("t3_ar1", {ar_log_addr[1], ar_log_len[1]}, {32'h100, 8'd15});
      check("t3_ar2", {ar_log_addr[2], ar_log_len[2]}, {32'h200, 8'd7});
      check("t3_beats", out_cnt, 40);

      // OUT_READY back-pressure mid-burst.
      fork
         begin issue_cmd(32'h5000, 12, -1); wait_done("t4"); end
         stall_out(3);
      join
      check("t4_beats", out_cnt, 12);
      check("t4_last_count", last_cnt, 1);

      // SLVERR on beat 2 makes ERR sticky until the next nonzero command.
      issue_cmd(32'h3000, 6, 1);
      wait_done("t5");
      repeat (3) @(posedge clk);
      #1 check("t5_err_sticky", ERR, 1);
      issue_cmd(32'h3100, 2, -1);
      check("t5_err_cleared", ERR, 0);
      wait_done("t5b");

      // Asynchronous reset while beat 3 of 8 is on the bus.
      issue_cmd(32'h4000, 8, -1);
      n = 0;
      while (!(out_cnt == 2 && OUT_VALID) && n < 300) begin @(negedge clk); n++; end
      check("t6_reached_beat3", out_cnt, 2);
      #1 rst = 1;
      #1;
      check("t6_rst_outputs", {ARVALID, RREADY, OUT_VALID, OUT_LAST, BUSY, DONE, ERR}, 0);
      check("t6_rst_ar_fields", {ARADDR, ARLEN}, 0);
      exp_q.delete(); exp_ar_q.delete(); exp_err = 0;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      issue_cmd(32'h2000, 2, -1);
      wait_done("t6");
      check("t6_ar0", {ar_log_addr[0], ar_log_len[0]}, {32'h2000, 8'd1});
      check("t6_beats", out_cnt, 2);

      // Zero-beat command: DONE next cycle, no AR.
      issue_cmd(32'h6000, 0, -1);
      check("t7_done_next", DONE, 1);
      check("t7_busy", BUSY, 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t7_no_ar", ARVALID, 0);
      end
      check("t7_ar_count", ar_n, 0);

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
